// File: rtl/radar_sim_pkg.sv
// Shared radar simulation types: width helper and recorder state encoding.
package radar_sim_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        CAPTURE = ST_CAPTURE,
        DONE    = ST_DONE
    } rec_state_e;

    // Bits needed to hold the value itself, so a count of SIZE ones always fits.
    function automatic int clogb2(input int value);
        int r;
        int v;
        r = 0;
        v = value;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/azimuth_signal_recorder_if.sv
// Control inputs and published-sweep outputs of the azimuth signal recorder.
interface azimuth_signal_recorder_if #(parameter int SIZE = 3200);
    import radar_sim_pkg::*;

    localparam int BITS = clogb2(SIZE);

    logic            EN;
    logic            TRIG;
    logic            CLK_PE;
    logic            SIG_IN;
    logic            DATA_ACK;
    logic [SIZE-1:0] DATA;
    logic            DATA_VALID;
    logic            OVERRUN;
    logic [BITS-1:0] HIT_COUNT;
    logic            BUSY;

    modport master (
        output EN, TRIG, CLK_PE, SIG_IN, DATA_ACK,
        input  DATA, DATA_VALID, OVERRUN, HIT_COUNT, BUSY
    );

    modport slave (
        input  EN, TRIG, CLK_PE, SIG_IN, DATA_ACK,
        output DATA, DATA_VALID, OVERRUN, HIT_COUNT, BUSY
    );

endinterface

// File: rtl/azimuth_hit_counter.sv
// Running ones counter for a sweep; clr restarts it, latch publishes the total.
module azimuth_hit_counter #(
    parameter int BITS = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    input  logic            din,
    input  logic            latch,
    output logic [BITS-1:0] hit_count
);

    logic [BITS-1:0] count_q, count_d;
    logic [BITS-1:0] hit_q, hit_d;

    always_comb begin
        count_d = count_q;
        hit_d   = hit_q;
        // latch reads the pre-clear total when a new sweep restarts in the same cycle
        if (latch) begin
            hit_d = count_q;
        end
        if (clr) begin
            count_d = '0;
        end else if (inc && din) begin
            count_d = count_q + BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            hit_q   <= '0;
        end else begin
            count_q <= count_d;
            hit_q   <= hit_d;
        end
    end

    assign hit_count = hit_q;

endmodule

// File: rtl/azimuth_signal_recorder.sv
// Captures one SIZE-sample azimuth sweep on CLK_PE strobes and publishes it with valid/ack.
// Hit counting is built only when RECORDER_HIT_COUNT_EN is defined; otherwise HIT_COUNT reads 0.
module azimuth_signal_recorder
    import radar_sim_pkg::*;
#(
    parameter int SIZE = 3200
) (
    input  logic                     SYS_CLK,
    input  logic                     SYS_RST,
    azimuth_signal_recorder_if.slave rec
);

    localparam int BITS = clogb2(SIZE);

    rec_state_e      state_q, state_d;
    logic [BITS-1:0] idx_q, idx_d;
    logic [SIZE-1:0] shadow_q, shadow_d;
    logic [SIZE-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;
    logic            cnt_clr;
    logic            cnt_inc;
    logic            cnt_latch;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        cnt_latch = 1'b0;

        if (valid_q && rec.DATA_ACK) begin
            valid_d = 1'b0;
        end

        if (!rec.EN) begin
            state_d  = IDLE;
            idx_d    = '0;
            shadow_d = '0;
            cnt_clr  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rec.TRIG) begin
                        state_d  = CAPTURE;
                        idx_d    = '0;
                        shadow_d = '0;
                        cnt_clr  = 1'b1;
                    end
                end
                CAPTURE: begin
                    // TRIG wins over a coincident strobe: the strobe is dropped.
                    if (rec.TRIG) begin
                        idx_d    = '0;
                        shadow_d = '0;
                        cnt_clr  = 1'b1;
                    end else if (rec.CLK_PE) begin
                        for (int i = 0; i < SIZE; i++) begin
                            if (idx_q == BITS'(i)) begin
                                shadow_d[i] = rec.SIG_IN;
                            end
                        end
                        cnt_inc = 1'b1;
                        if (idx_q == BITS'(SIZE - 1)) begin
                            state_d = DONE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + BITS'(1);
                        end
                    end
                end
                DONE: begin
                    data_d    = shadow_q;
                    valid_d   = 1'b1;
                    cnt_latch = 1'b1;
                    if (valid_q && !rec.DATA_ACK) begin
                        overrun_d = 1'b1;
                    end
                    if (rec.TRIG) begin
                        state_d  = CAPTURE;
                        idx_d    = '0;
                        shadow_d = '0;
                        cnt_clr  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            shadow_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef RECORDER_HIT_COUNT_EN
    azimuth_hit_counter #(
        .BITS (BITS)
    ) u_hit_counter (
        .clk       (SYS_CLK),
        .rst       (SYS_RST),
        .clr       (cnt_clr),
        .inc       (cnt_inc),
        .din       (rec.SIG_IN),
        .latch     (cnt_latch),
        .hit_count (rec.HIT_COUNT)
    );
`else
    logic unused_cnt;
    assign unused_cnt    = cnt_clr ^ cnt_inc ^ cnt_latch;
    assign rec.HIT_COUNT = '0;
`endif

    assign rec.DATA       = data_q;
    assign rec.DATA_VALID = valid_q;
    assign rec.OVERRUN    = overrun_q;
    assign rec.BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_azimuth_signal_recorder.sv
// Directed bench for azimuth_signal_recorder at SIZE=16; inputs change on negedge, outputs read on negedge.
module tb_azimuth_signal_recorder;

    localparam int SIZE = 16;
`ifdef RECORDER_HIT_COUNT_EN
    localparam int HC_ON = 1;
`else
    localparam int HC_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors    = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    azimuth_signal_recorder_if #(.SIZE(SIZE)) bus ();

    azimuth_signal_recorder #(.SIZE(SIZE)) dut (
        .SYS_CLK (clk),
        .SYS_RST (rst),
        .rec     (bus)
    );

    task automatic trig();
        bus.TRIG = 1'b1;
        @(negedge clk);
        bus.TRIG = 1'b0;
    endtask

    task automatic strobes(input logic [15:0] pat, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap - 1) @(negedge clk);
            bus.CLK_PE = 1'b1;
            bus.SIG_IN = pat[i];
            @(negedge clk);
            bus.CLK_PE = 1'b0;
            bus.SIG_IN = 1'b0;
        end
    endtask

    task automatic sweep(input logic [15:0] pat, input int gap);
        trig();
        strobes(pat, 16, gap);
    endtask

    task automatic ack();
        bus.DATA_ACK = 1'b1;
        @(negedge clk);
        bus.DATA_ACK = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (bus.DATA !== 16'h0000) begin miscompares++; $display("FAIL reset_data got %h want 0000", bus.DATA); end
        vectors++; if (bus.DATA_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.DATA_VALID); end
        vectors++; if (bus.OVERRUN !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", bus.OVERRUN); end
        vectors++; if (bus.HIT_COUNT !== 5'd0) begin miscompares++; $display("FAIL reset_hit got %0d want 0", bus.HIT_COUNT); end
        vectors++; if (bus.BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.BUSY); end
        rst = 1'b0;
    endtask

    task automatic test_loopback();
        sweep(16'hA5C3, 3);
        // one edge after the last strobe: DONE, nothing published yet
        vectors++; if (bus.DATA_VALID !== 1'b0) begin miscompares++; $display("FAIL loop_valid_early got %b want 0", bus.DATA_VALID); end
        vectors++; if (bus.BUSY !== 1'b1) begin miscompares++; $display("FAIL loop_busy_done got %b want 1", bus.BUSY); end
        @(negedge clk);
        vectors++; if (bus.DATA_VALID !== 1'b1) begin miscompares++; $display("FAIL loop_valid got %b want 1", bus.DATA_VALID); end
        vectors++; if (bus.DATA !== 16'hA5C3) begin miscompares++; $display("FAIL loop_data got %h want a5c3", bus.DATA); end
        vectors++; if (bus.HIT_COUNT !== 5'(HC_ON * 8)) begin miscompares++; $display("FAIL loop_hit got %0d want %0d", bus.HIT_COUNT, HC_ON * 8); end
        vectors++; if (bus.OVERRUN !== 1'b0) begin miscompares++; $display("FAIL loop_overrun got %b want 0", bus.OVERRUN); end
        vectors++; if (bus.BUSY !== 1'b0) begin miscompares++; $display("FAIL loop_busy_idle got %b want 0", bus.BUSY); end
        ack();
        vectors++; if (bus.DATA_VALID !== 1'b0) begin miscompares++; $display("FAIL loop_ack_valid got %b want 0", bus.DATA_VALID); end
        vectors++; if (bus.DATA !== 16'hA5C3) begin miscompares++; $display("FAIL loop_ack_data got %h want a5c3", bus.DATA); end
    endtask

    task automatic test_back_to_back();
        sweep(16'h00FF, 1);
        sweep(16'hFFFF, 1);
        @(negedge clk);
        vectors++; if (bus.DATA !== 16'hFFFF) begin miscompares++; $display("FAIL b2b_data got %h want ffff", bus.DATA); end
        vectors++; if (bus.HIT_COUNT !== 5'(HC_ON * 16)) begin miscompares++; $display("FAIL b2b_hit got %0d want %0d", bus.HIT_COUNT, HC_ON * 16); end
        vectors++; if (bus.OVERRUN !== 1'b1) begin miscompares++; $display("FAIL b2b_overrun got %b want 1", bus.OVERRUN); end
    endtask

    task automatic test_rst_mid_capture();
        trig();
        strobes(16'hFFFF, 5, 1);
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (bus.BUSY !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", bus.BUSY); end
        vectors++; if (bus.DATA !== 16'h0000) begin miscompares++; $display("FAIL rstmid_data got %h want 0000", bus.DATA); end
        vectors++; if (bus.DATA_VALID !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid got %b want 0", bus.DATA_VALID); end
        vectors++; if (bus.OVERRUN !== 1'b0) begin miscompares++; $display("FAIL rstmid_overrun got %b want 0", bus.OVERRUN); end
        vectors++; if (bus.HIT_COUNT !== 5'd0) begin miscompares++; $display("FAIL rstmid_hit got %0d want 0", bus.HIT_COUNT); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back_ack();
        sweep(16'h00FF, 1);
        sweep(16'hFFFF, 1);
        // acknowledge in the second DONE cycle
        ack();
        vectors++; if (bus.DATA_VALID !== 1'b1) begin miscompares++; $display("FAIL b2back_valid got %b want 1", bus.DATA_VALID); end
        vectors++; if (bus.OVERRUN !== 1'b0) begin miscompares++; $display("FAIL b2back_overrun got %b want 0", bus.OVERRUN); end
        vectors++; if (bus.DATA !== 16'hFFFF) begin miscompares++; $display("FAIL b2back_data got %h want ffff", bus.DATA); end
        ack();
    endtask

    task automatic test_restart();
        trig();
        strobes(16'hFFFF, 7, 1);
        sweep(16'h0001, 2);
        @(negedge clk);
        vectors++; if (bus.DATA !== 16'h0001) begin miscompares++; $display("FAIL restart_data got %h want 0001", bus.DATA); end
        vectors++; if (bus.HIT_COUNT !== 5'(HC_ON * 1)) begin miscompares++; $display("FAIL restart_hit got %0d want %0d", bus.HIT_COUNT, HC_ON); end
        vectors++; if (bus.OVERRUN !== 1'b0) begin miscompares++; $display("FAIL restart_overrun got %b want 0", bus.OVERRUN); end
        ack();
    endtask

    task automatic test_trig_collision();
        trig();
        strobes(16'h0001, 1, 1);
        bus.TRIG   = 1'b1;
        bus.CLK_PE = 1'b1;
        bus.SIG_IN = 1'b1;
        @(negedge clk);
        bus.TRIG   = 1'b0;
        bus.CLK_PE = 1'b0;
        bus.SIG_IN = 1'b0;
        strobes(16'h0002, 16, 2);
        @(negedge clk);
        vectors++; if (bus.DATA !== 16'h0002) begin miscompares++; $display("FAIL collide_data got %h want 0002", bus.DATA); end
        vectors++; if (bus.HIT_COUNT !== 5'(HC_ON * 1)) begin miscompares++; $display("FAIL collide_hit got %0d want %0d", bus.HIT_COUNT, HC_ON); end
        ack();
    endtask

    task automatic test_en_drop();
        trig();
        strobes(16'hFFFF, 5, 1);
        bus.EN = 1'b0;
        @(negedge clk);
        bus.EN = 1'b1;
        vectors++; if (bus.BUSY !== 1'b0) begin miscompares++; $display("FAIL endrop_busy got %b want 0", bus.BUSY); end
        vectors++; if (bus.DATA !== 16'h0002) begin miscompares++; $display("FAIL endrop_data got %h want 0002", bus.DATA); end
        vectors++; if (bus.DATA_VALID !== 1'b0) begin miscompares++; $display("FAIL endrop_valid got %b want 0", bus.DATA_VALID); end
        // strobes without a fresh TRIG must not be captured
        strobes(16'hFFFF, 16, 1);
        @(negedge clk);
        vectors++; if (bus.DATA_VALID !== 1'b0) begin miscompares++; $display("FAIL endrop_notrig_valid got %b want 0", bus.DATA_VALID); end
        vectors++; if (bus.BUSY !== 1'b0) begin miscompares++; $display("FAIL endrop_notrig_busy got %b want 0", bus.BUSY); end
    endtask

    initial begin
        bus.EN       = 1'b1;
        bus.TRIG     = 1'b0;
        bus.CLK_PE   = 1'b0;
        bus.SIG_IN   = 1'b0;
        bus.DATA_ACK = 1'b0;
        @(negedge clk);
        test_reset();
        test_loopback();
        test_back_to_back();
        test_rst_mid_capture();
        test_back_to_back_ack();
        test_restart();
        test_trig_collision();
        test_en_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
